// File: rtl/store_buffer.sv
// Committed-store FIFO between MEM and Data_Memory with load overlap detection.
// Define STORE_FWD_EN to forward exact-match store data to loads.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [31:0]              st_data,
  input  logic [1:0]               st_width,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [1:0]               ld_width,
  input  logic                     ld_sext,
  output logic                     ld_hazard,
  output logic                     ld_fwd_valid,
  output logic [31:0]              ld_fwd_data,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_data,
  output logic [1:0]               mem_width,
  output logic                     mem_write,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] e_addr  [DEPTH];
  logic [31:0]       e_data  [DEPTH];
  logic [1:0]        e_width [DEPTH];
  logic [DEPTH-1:0]  e_vld;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  assign st_ready  = (count != CW'(DEPTH));
  assign empty     = (count == '0);
  assign mem_write = !empty && !ld_valid;
  assign pop       = mem_write;
  assign push      = st_valid && st_ready && (st_width != 2'b11);
  assign mem_addr  = e_addr[rd_ptr];
  assign mem_data  = e_data[rd_ptr];
  assign mem_width = e_width[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      e_vld  <= '0;
    end else begin
      if (push) begin
        wr_ptr         <= wr_ptr + 1'b1;
        e_vld[wr_ptr]  <= 1'b1;
      end
      if (pop) begin
        rd_ptr         <= rd_ptr + 1'b1;
        e_vld[rd_ptr]  <= 1'b0;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      e_addr[wr_ptr]  <= st_addr;
      e_data[wr_ptr]  <= st_data;
      e_width[wr_ptr] <= st_width;
    end
  end

  function automatic logic [ADDR_W:0] span(input logic [1:0] w);
    unique case (w)
      2'b00:   span = (ADDR_W+1)'(0);
      2'b01:   span = (ADDR_W+1)'(1);
      default: span = (ADDR_W+1)'(3);
    endcase
  endfunction

  // Extra top bit keeps ranges that run past the address wrap from aliasing low bytes.
  logic [ADDR_W:0]  ld_lo;
  logic [ADDR_W:0]  ld_hi;
  logic [DEPTH-1:0] ov;
  logic             any_ov;

  always_comb begin
    ld_lo = {1'b0, ld_addr};
    ld_hi = ld_lo + span(ld_width);
    ov    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ov[i] = e_vld[i] && (ld_width != 2'b11)
           && ({1'b0, e_addr[i]} <= ld_hi)
           && (ld_lo <= ({1'b0, e_addr[i]} + span(e_width[i])));
    end
    any_ov = |ov;
  end

`ifdef STORE_FWD_EN
  logic [PW-1:0] yng;
  logic [PW-1:0] idx;
  logic          found;
  logic          hit;
  logic [31:0]   raw;

  // Scan oldest to youngest so the last overlapping entry wins.
  always_comb begin
    yng   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (ov[idx]) begin
        yng   = idx;
        found = 1'b1;
      end
    end
  end

  assign hit = ld_valid && found
            && (e_addr[yng] == ld_addr)
            && (e_width[yng] == ld_width);
  assign raw = e_data[yng];

  always_comb begin
    ld_fwd_data = '0;
    if (hit) begin
      unique case (ld_width)
        2'b00:   ld_fwd_data = {{24{ld_sext & raw[7]}}, raw[7:0]};
        2'b01:   ld_fwd_data = {{16{ld_sext & raw[15]}}, raw[15:0]};
        default: ld_fwd_data = raw;
      endcase
    end
  end

  assign ld_fwd_valid = hit;
`else
  logic unused;
  assign unused       = ld_sext;
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = '0;
`endif

  assign ld_hazard = ld_valid && any_ov && !ld_fwd_valid;

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue model.
// Build with or without STORE_FWD_EN to match the design.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk;
  logic          rst_n;
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [1:0]    st_width;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [1:0]    ld_width;
  logic          ld_sext;
  logic          ld_hazard;
  logic          ld_fwd_valid;
  logic [31:0]   ld_fwd_data;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic [1:0]    mem_width;
  logic          mem_write;
  logic          empty;
  logic [$clog2(DEPTH):0] count;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_width(st_width),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_width(ld_width), .ld_sext(ld_sext),
    .ld_hazard(ld_hazard), .ld_fwd_valid(ld_fwd_valid),
    .ld_fwd_data(ld_fwd_data),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_width(mem_width), .mem_write(mem_write),
    .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  width;
  } ent_t;

  ent_t q[$];
  int   n_chk;
  int   n_fail;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint msz(logic [1:0] w);
    case (w)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  task automatic model_check();
    bit          any;
    bit          fwd;
    int          y;
    longint      llo, lhi, slo, shi;
    logic [31:0] fd;
    logic [31:0] raw;
    any = 0;
    fwd = 0;
    y   = -1;
    fd  = '0;
    raw = '0;
    chk("st_ready", 64'(st_ready), 64'(q.size() != DEPTH));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("count", 64'(count), 64'(q.size()));
    chk("mem_write", 64'(mem_write), 64'(q.size() > 0 && !ld_valid));
    if (q.size() > 0) begin
      chk("mem_addr", 64'(mem_addr), 64'(q[0].addr));
      chk("mem_data", 64'(mem_data), 64'(q[0].data));
      chk("mem_width", 64'(mem_width), 64'(q[0].width));
    end
    llo = longint'(ld_addr);
    lhi = llo + msz(ld_width) - 1;
    if (ld_width != 2'b11) begin
      foreach (q[i]) begin
        slo = longint'(q[i].addr);
        shi = slo + msz(q[i].width) - 1;
        if (slo <= lhi && llo <= shi) begin
          any = 1;
          y   = i;
        end
      end
    end
`ifdef STORE_FWD_EN
    if (ld_valid && any && q[y].addr == ld_addr && q[y].width == ld_width) begin
      fwd = 1;
      raw = q[y].data;
      case (ld_width)
        2'b00:   fd = ld_sext ? {{24{raw[7]}}, raw[7:0]} : {24'b0, raw[7:0]};
        2'b01:   fd = ld_sext ? {{16{raw[15]}}, raw[15:0]} : {16'b0, raw[15:0]};
        default: fd = raw;
      endcase
    end
`endif
    chk("ld_hazard", 64'(ld_hazard), 64'(ld_valid && any && !fwd));
    chk("ld_fwd_valid", 64'(ld_fwd_valid), 64'(fwd));
    chk("ld_fwd_data", 64'(ld_fwd_data), 64'(fd));
  endtask

  task automatic cyc();
    bit do_pop;
    bit do_push;
    #2;
    model_check();
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
    end else begin
      do_pop  = q.size() > 0 && !ld_valid;
      do_push = st_valid && q.size() != DEPTH && st_width != 2'b11;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{st_addr, st_data, st_width});
    end
    #1;
  endtask

  task automatic idle();
    rst_n    = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_width = 2'b00;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_width = 2'b00;
    ld_sext  = 1'b0;
  endtask

  task automatic st(logic [31:0] a, logic [31:0] d, logic [1:0] w);
    idle();
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_width = w;
  endtask

  task automatic ld(logic [31:0] a, logic [1:0] w, logic s);
    idle();
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_width = w;
    ld_sext  = s;
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(7) == 0) return 32'hFFFF_FFF0 + $urandom_range(15);
    return 32'h100 + $urandom_range(15);
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle();
    q.delete();

    cyc();
    st(32'h100, 32'hDEAD_BEEF, 2'b10);
    cyc();
    idle();
    #1;
    chk("sw_write", 64'(mem_write), 64'd1);
    chk("sw_addr", 64'(mem_addr), 64'h100);
    cyc();
    #1;
    chk("sw_empty", 64'(empty), 64'd1);
    cyc();

    for (int i = 0; i < DEPTH; i++) begin
      st(32'h200 + 32'(4 * i), 32'(i) * 32'h1111_1111, 2'b10);
      ld_valid = 1'b1;
      ld_addr  = 32'h800;
      ld_width = 2'b10;
      cyc();
    end
    ld(32'h800, 2'b10, 1'b0);
    #1;
    chk("full_ready", 64'(st_ready), 64'd0);
    chk("full_nowrite", 64'(mem_write), 64'd0);
    cyc();
    idle();
    repeat (DEPTH + 1) cyc();

    st(32'h102, 32'h8001, 2'b01);
    cyc();
    ld(32'h103, 2'b00, 1'b0);
    #1;
    chk("hz_lb103", 64'(ld_hazard), 64'd1);
    cyc();
    ld(32'h104, 2'b10, 1'b0);
    #1;
    chk("hz_lw104", 64'(ld_hazard), 64'd0);
    cyc();
    ld(32'h101, 2'b10, 1'b0);
    #1;
    chk("hz_lw101", 64'(ld_hazard), 64'd1);
    cyc();
    idle();
    cyc();

    st(32'h10, 32'h80, 2'b00);
    cyc();
    ld(32'h10, 2'b00, 1'b1);
    #1;
`ifdef STORE_FWD_EN
    chk("fwd_valid", 64'(ld_fwd_valid), 64'd1);
    chk("fwd_data", 64'(ld_fwd_data), 64'hFFFF_FF80);
    chk("fwd_nohz", 64'(ld_hazard), 64'd0);
`else
    chk("nofwd_hz", 64'(ld_hazard), 64'd1);
`endif
    cyc();
    idle();
    cyc();

    st(32'h300, 32'h1234, 2'b11);
    #1;
    chk("noop_ready", 64'(st_ready), 64'd1);
    cyc();
    idle();
    #1;
    chk("noop_count", 64'(count), 64'd0);
    chk("noop_nowrite", 64'(mem_write), 64'd0);
    cyc();

    for (int i = 0; i < 3; i++) begin
      st(32'h500 + 32'(4 * i), $urandom, 2'b10);
      ld_valid = 1'b1;
      ld_addr  = 32'h900;
      cyc();
    end
    idle();
    rst_n = 1'b0;
    cyc();
    idle();
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_nowrite", 64'(mem_write), 64'd0);
    cyc();

    for (int i = 0; i < 3 * DEPTH; i++) begin
      st(32'h400 + 32'(4 * i), $urandom, 2'(i % 3));
      cyc();
    end
    idle();
    repeat (DEPTH + 1) cyc();

    for (int i = 0; i < 800; i++) begin
      idle();
      st_valid = 1'($urandom_range(1));
      st_addr  = rnd_addr();
      st_data  = $urandom;
      st_width = 2'($urandom_range(3));
      ld_valid = ($urandom_range(2) == 0);
      ld_addr  = rnd_addr();
      ld_width = 2'($urandom_range(3));
      ld_sext  = 1'($urandom_range(1));
      rst_n    = ($urandom_range(99) != 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
